// File: rtl/fifo_pkg.sv
// Shared definitions for the packing FIFO: derived-width helpers and the
// lane-valid mask function.
package fifo_pkg;

  // Widths for the default configuration (16-bit words, 4:1 packing, 128 deep).
  localparam int unsigned pIN_WIDTH_DEF = 16;
  localparam int unsigned pRATIO_DEF    = 4;
  localparam int unsigned pDEPTH_DEF    = 128;

  localparam int unsigned pOUT_WIDTH   = pIN_WIDTH_DEF * pRATIO_DEF;
  localparam int unsigned pADDR_WIDTH  = $clog2(pDEPTH_DEF);
  localparam int unsigned pCOUNT_WIDTH = pADDR_WIDTH + 1;
  localparam int unsigned pLANE_WIDTH  = $clog2(pRATIO_DEF) + 1;

  // Derived widths for an arbitrary configuration.
  function automatic int unsigned out_width(input int unsigned in_w, input int unsigned ratio);
    return in_w * ratio;
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned lane_width(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

  // Mask with the low n bits set (saturates at 32 lanes).
  function automatic logic [31:0] lane_mask(input int unsigned n);
    if (n >= 32) return '1;
    return (32'h1 << n) - 32'h1;
  endfunction

endpackage

// File: rtl/fifo_packer.sv
// Narrow-to-wide packer: collects pRATIO write words into one wide word and
// produces a push request with its lane-valid mask on completion or flush.
module fifo_packer
  import fifo_pkg::*;
#(
  parameter  int unsigned pIN_WIDTH  = 16,
  parameter  int unsigned pRATIO     = 4,
  parameter  int unsigned pLSB_FIRST = 1,
  localparam int unsigned OUT_W      = out_width(pIN_WIDTH, pRATIO),
  localparam int unsigned LANE_W     = lane_width(pRATIO)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic [pIN_WIDTH-1:0] wdata_i,
  input  logic                 flush_i,
  input  logic                 room_i,
  output logic                 push_o,
  output logic                 push_blocked_o,
  output logic [OUT_W-1:0]     push_data_o,
  output logic [pRATIO-1:0]    push_mask_o,
  output logic [LANE_W-1:0]    lane_count_o
);

  logic [pRATIO-1:0][pIN_WIDTH-1:0] lanes_q, lanes_d, lanes_w;
  logic [LANE_W-1:0]                cnt_q, cnt_d, cnt_w, lane_sel;
  logic                             word_done, flush_req, push_req;
  logic [pRATIO-1:0]                mask_lo;

  // Absorb the write first, then decide whether the result is pushed.
  always_comb begin
    lane_sel = (pLSB_FIRST != 0) ? cnt_q : (LANE_W'(pRATIO - 1) - cnt_q);
    lanes_w  = lanes_q;
    for (int unsigned i = 0; i < pRATIO; i++) begin
      if (wr_i && (lane_sel == LANE_W'(i))) lanes_w[i] = wdata_i;
    end
    cnt_w          = cnt_q + LANE_W'(wr_i);
    word_done      = (cnt_w == LANE_W'(pRATIO));
    flush_req      = flush_i && (cnt_w != '0) && !word_done;
    push_req       = word_done || flush_req;
    push_o         = push_req && room_i;
    // A blocked push keeps the packer contents (including a same-cycle write).
    push_blocked_o = push_req && !room_i;
    mask_lo        = pRATIO'(lane_mask(32'(cnt_w)));
    if (pLSB_FIRST != 0) push_mask_o = mask_lo;
    else                 push_mask_o = {<<{mask_lo}};
    push_data_o    = lanes_w;
    if (push_o) begin
      lanes_d = '0;
      cnt_d   = '0;
    end else begin
      lanes_d = lanes_w;
      cnt_d   = cnt_w;
    end
  end

  // Lane register and fill count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lane_count_o = cnt_q;

endmodule

// File: rtl/fifo_sync_pack.sv
// Single-clock packing FIFO: narrow writes are packed into wide words with a
// lane mask and buffered for a wide reader; exports fill level and flags.
module fifo_sync_pack
  import fifo_pkg::*;
#(
  parameter  int unsigned pIN_WIDTH    = 16,
  parameter  int unsigned pRATIO       = 4,
  parameter  int unsigned pDEPTH       = 128,
  parameter  int unsigned pFALLTHROUGH = 0,
  parameter  int unsigned pLSB_FIRST   = 1,
  localparam int unsigned OUT_W        = out_width(pIN_WIDTH, pRATIO),
  localparam int unsigned ADDR_W       = addr_width(pDEPTH),
  localparam int unsigned CNT_W        = count_width(pDEPTH),
  localparam int unsigned LANE_W       = lane_width(pRATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          full_threshold_value,
  input  logic [31:0]          empty_threshold_value,
  input  logic                 wen,
  input  logic [pIN_WIDTH-1:0] wdata,
  input  logic                 flush,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 full_threshold,
  input  logic                 ren,
  output logic [OUT_W-1:0]     rdata,
  output logic [pRATIO-1:0]    rlanes,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 underflow,
  output logic                 empty_threshold,
  output logic [CNT_W-1:0]     count,
  output logic [LANE_W-1:0]    lane_count
);

  localparam int unsigned       ENTRY_W   = OUT_W + pRATIO;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(pDEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_M1  = CNT_W'(pDEPTH - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(pRATIO - 1);

  logic [ENTRY_W-1:0] mem_q [pDEPTH];
  logic [ADDR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LANE_W-1:0]  lane_cnt;
  logic               room, full_w, wr_ok, pop, push, push_blocked;
  logic [OUT_W-1:0]   push_data;
  logic [pRATIO-1:0]  push_mask;
  logic [ENTRY_W-1:0] head;
  logic               ovf_q, udf_q;

  assign room   = (count_q != DEPTH_C);
  assign full_w = !room && (lane_cnt == LAST_LANE);
  assign wr_ok  = wen && !full_w;
  assign pop    = ren && (count_q != '0);

  fifo_packer #(
    .pIN_WIDTH  (pIN_WIDTH),
    .pRATIO     (pRATIO),
    .pLSB_FIRST (pLSB_FIRST)
  ) u_packer (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_i           (wr_ok),
    .wdata_i        (wdata),
    .flush_i        (flush),
    .room_i         (room),
    .push_o         (push),
    .push_blocked_o (push_blocked),
    .push_data_o    (push_data),
    .push_mask_o    (push_mask),
    .lane_count_o   (lane_cnt)
  );

  // Fill level: a push and a pop in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, fill level and one-cycle error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + ADDR_W'(1);
      if (pop)  rptr_q <= rptr_q + ADDR_W'(1);
      count_q <= count_d;
      ovf_q   <= (wen && full_w) || push_blocked;
      udf_q   <= ren && (count_q == '0);
    end
  end

  // Storage array: mask in the top pRATIO bits, data below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {push_mask, push_data};
  end

  assign head = mem_q[rptr_q];

  if (pFALLTHROUGH != 0) begin : g_fwft
    // Head word shown directly while anything is stored.
    always_comb begin
      rdata  = '0;
      rlanes = '0;
      if (count_q != '0) begin
        rdata  = head[OUT_W-1:0];
        rlanes = head[ENTRY_W-1:OUT_W];
      end
    end
  end else begin : g_std
    logic [OUT_W-1:0]  rdata_q;
    logic [pRATIO-1:0] rlanes_q;
    // Registered read port, updated only by an accepted read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rlanes_q <= '0;
      end else if (pop) begin
        rdata_q  <= head[OUT_W-1:0];
        rlanes_q <= head[ENTRY_W-1:OUT_W];
      end
    end
    assign rdata  = rdata_q;
    assign rlanes = rlanes_q;
  end

  assign full            = full_w;
  assign almost_full     = (count_q >= DEPTH_M1);
  assign overflow        = ovf_q;
  assign full_threshold  = (32'(count_q) >= full_threshold_value);
  assign empty           = (count_q == '0);
  assign almost_empty    = (count_q <= CNT_W'(1));
  assign underflow       = udf_q;
  assign empty_threshold = (32'(count_q) <= empty_threshold_value);
  assign count           = count_q;
  assign lane_count      = lane_cnt;

endmodule

// File: tb/tb_fifo_sync_pack.sv
// Directed self-checking bench for fifo_sync_pack (standard and fall-through).
module tb_fifo_sync_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ftv, etv;
  logic        wen, flush, ren;
  logic [15:0] wdata;

  logic        full_a, afull_a, ovf_a, fth_a, empty_a, aempty_a, udf_a, eth_a;
  logic [63:0] rdata_a;
  logic [3:0]  rlanes_a;
  logic [7:0]  count_a;
  logic [2:0]  lane_a;

  logic        full_b, afull_b, ovf_b, fth_b, empty_b, aempty_b, udf_b, eth_b;
  logic [63:0] rdata_b;
  logic [3:0]  rlanes_b;
  logic [7:0]  count_b;
  logic [2:0]  lane_b;

  fifo_sync_pack #(.pIN_WIDTH(16), .pRATIO(4), .pDEPTH(128), .pFALLTHROUGH(0), .pLSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .full_threshold_value(ftv), .empty_threshold_value(etv),
    .wen(wen), .wdata(wdata), .flush(flush), .full(full_a), .almost_full(afull_a),
    .overflow(ovf_a), .full_threshold(fth_a), .ren(ren), .rdata(rdata_a), .rlanes(rlanes_a),
    .empty(empty_a), .almost_empty(aempty_a), .underflow(udf_a), .empty_threshold(eth_a),
    .count(count_a), .lane_count(lane_a));

  fifo_sync_pack #(.pIN_WIDTH(16), .pRATIO(4), .pDEPTH(128), .pFALLTHROUGH(1), .pLSB_FIRST(1)) dut_ft (
    .clk(clk), .rst(rst), .full_threshold_value(ftv), .empty_threshold_value(etv),
    .wen(wen), .wdata(wdata), .flush(flush), .full(full_b), .almost_full(afull_b),
    .overflow(ovf_b), .full_threshold(fth_b), .ren(ren), .rdata(rdata_b), .rlanes(rlanes_b),
    .empty(empty_b), .almost_empty(aempty_b), .underflow(udf_b), .empty_threshold(eth_b),
    .count(count_b), .lane_count(lane_b));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] d, input logic f, input logic r);
    wen = w; wdata = d; flush = f; ren = r;
  endtask

  function automatic logic [63:0] word_of(input int k);
    return {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
  endfunction

  typedef struct {
    logic        wen;
    logic [15:0] wdata;
    logic        flush;
    logic        ren;
    logic [7:0]  e_count;
    logic [2:0]  e_lane;
    logic        e_empty;
    logic        e_ovf;
    logic        e_udf;
    logic [63:0] e_rdata;
    logic [3:0]  e_rlanes;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [15:0] d, input logic f, input logic r,
                              input logic [7:0] c, input logic [2:0] l, input logic e,
                              input logic o, input logic u, input logic [63:0] rd, input logic [3:0] rl);
    vec_t v;
    v.wen = w; v.wdata = d; v.flush = f; v.ren = r;
    v.e_count = c; v.e_lane = l; v.e_empty = e; v.e_ovf = o; v.e_udf = u;
    v.e_rdata = rd; v.e_rlanes = rl;
    return v;
  endfunction

  localparam logic [63:0] R1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] R2 = 64'h0000_0000_BBBB_AAAA;
  localparam logic [63:0] R3 = 64'h0000_0000_0000_0101;
  localparam logic [63:0] R4 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] R5 = 64'h000C_000B_000A_0009;
  localparam logic [63:0] R6 = 64'h0010_000F_000E_000D;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ftv = 32'd0; etv = 32'd2;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    // Reset state
    check("rst_count", count_a, 0);
    check("rst_lane", lane_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_rlanes", rlanes_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_aempty", aempty_a, 1);
    check("rst_full", full_a, 0);
    check("rst_afull", afull_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_udf", udf_a, 0);
    check("rst_eth", eth_a, 1);
    check("rst_fth_zero", fth_a, 1);
    check("rst_ft_rdata", rdata_b, 0);
    ftv = 32'd96;
    #1;
    check("rst_fth_96", fth_a, 0);
    rst = 1'b0;

    //            wen  wdata     fl   ren  cnt lane emp ovf udf rdata rlanes
    tbl.push_back(mk(1, 16'h0001, 0, 0, 0, 1, 1, 0, 0, 64'h0, 4'h0));
    tbl.push_back(mk(1, 16'h0002, 0, 0, 0, 2, 1, 0, 0, 64'h0, 4'h0));
    tbl.push_back(mk(1, 16'h0003, 0, 0, 0, 3, 1, 0, 0, 64'h0, 4'h0));
    tbl.push_back(mk(1, 16'h0004, 0, 0, 1, 0, 0, 0, 0, 64'h0, 4'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, R1, 4'hF));
    tbl.push_back(mk(1, 16'hAAAA, 0, 0, 0, 1, 1, 0, 0, R1, 4'hF));
    tbl.push_back(mk(1, 16'hBBBB, 0, 0, 0, 2, 1, 0, 0, R1, 4'hF));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, R1, 4'hF));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, R2, 4'h3));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 0, 1, R2, 4'h3));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, R2, 4'h3));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 0, 0, R2, 4'h3));
    tbl.push_back(mk(1, 16'h0101, 1, 0, 1, 0, 0, 0, 0, R2, 4'h3));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 1, 1, 0, 0, 0, R2, 4'h3));
    tbl.push_back(mk(1, 16'h0006, 0, 0, 1, 2, 0, 0, 0, R2, 4'h3));
    tbl.push_back(mk(1, 16'h0007, 0, 0, 1, 3, 0, 0, 0, R2, 4'h3));
    tbl.push_back(mk(1, 16'h0008, 1, 0, 2, 0, 0, 0, 0, R2, 4'h3));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, R3, 4'h1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, R4, 4'hF));
    tbl.push_back(mk(1, 16'h0009, 0, 1, 0, 1, 1, 0, 1, R4, 4'hF));
    tbl.push_back(mk(1, 16'h000A, 0, 0, 0, 2, 1, 0, 0, R4, 4'hF));
    tbl.push_back(mk(1, 16'h000B, 0, 0, 0, 3, 1, 0, 0, R4, 4'hF));
    tbl.push_back(mk(1, 16'h000C, 0, 0, 1, 0, 0, 0, 0, R4, 4'hF));
    tbl.push_back(mk(1, 16'h000D, 0, 0, 1, 1, 0, 0, 0, R4, 4'hF));
    tbl.push_back(mk(1, 16'h000E, 0, 0, 1, 2, 0, 0, 0, R4, 4'hF));
    tbl.push_back(mk(1, 16'h000F, 0, 0, 1, 3, 0, 0, 0, R4, 4'hF));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 1, 0, 0, 0, 0, R5, 4'hF));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 0, 0, R6, 4'hF));

    foreach (tbl[i]) begin
      drive(tbl[i].wen, tbl[i].wdata, tbl[i].flush, tbl[i].ren);
      tick();
      check($sformatf("v%0d_count", i), count_a, tbl[i].e_count);
      check($sformatf("v%0d_lane", i), lane_a, tbl[i].e_lane);
      check($sformatf("v%0d_empty", i), empty_a, tbl[i].e_empty);
      check($sformatf("v%0d_ovf", i), ovf_a, tbl[i].e_ovf);
      check($sformatf("v%0d_udf", i), udf_a, tbl[i].e_udf);
      check($sformatf("v%0d_rdata", i), rdata_a, tbl[i].e_rdata);
      check($sformatf("v%0d_rlanes", i), rlanes_a, tbl[i].e_rlanes);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Fill to capacity, thresholds along the way
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 515; n++) begin
      int c, l;
      drive(1'b1, 16'(n + 1), 1'b0, 1'b0);
      tick();
      c = (n + 1) / 4;
      l = (n + 1) % 4;
      check($sformatf("fill%0d_count", n), count_a, 64'(c));
      check($sformatf("fill%0d_lane", n), lane_a, 64'(l));
      check($sformatf("fill%0d_fth", n), fth_a, 64'(c >= 96));
      check($sformatf("fill%0d_eth", n), eth_a, 64'(c <= 2));
      check($sformatf("fill%0d_afull", n), afull_a, 64'(c >= 127));
      check($sformatf("fill%0d_full", n), full_a, 64'(c == 128 && l == 3));
    end
    check("full_after_515", full_a, 1);

    drive(1'b1, 16'hDEAD, 1'b0, 1'b0); tick();
    check("drop_ovf", ovf_a, 1);
    check("drop_count", count_a, 128);
    check("drop_lane", lane_a, 3);
    drive(1'b0, 16'h0, 1'b0, 1'b0); tick();
    check("drop_ovf_clear", ovf_a, 0);
    drive(1'b0, 16'h0, 1'b1, 1'b0); tick();
    check("flushfull_ovf", ovf_a, 1);
    check("flushfull_count", count_a, 128);
    check("flushfull_lane", lane_a, 3);
    drive(1'b0, 16'h0, 1'b0, 1'b0); tick();
    check("flushfull_ovf_clear", ovf_a, 0);

    drive(1'b1, 16'hBEEF, 1'b0, 1'b1); tick();
    check("norescue_ovf", ovf_a, 1);
    check("norescue_count", count_a, 127);
    check("norescue_lane", lane_a, 3);
    check("norescue_rdata", rdata_a, word_of(0));
    for (int k = 1; k <= 32; k++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      tick();
      check($sformatf("drain%0d_rdata", k), rdata_a, word_of(k));
      check($sformatf("drain%0d_count", k), count_a, 64'(127 - k));
      check($sformatf("drain%0d_fth", k), fth_a, 64'(k < 32));
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Reset mid-packet with stored words present
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 16'(16'h90 + n), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("pre_rst_count", count_a, 1);
    check("pre_rst_lane", lane_a, 2);
    rst = 1'b1;
    #1;
    check("async_rst_count", count_a, 0);
    check("async_rst_lane", lane_a, 0);
    check("async_rst_empty", empty_a, 1);
    check("async_rst_ft_rdata", rdata_b, 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0011, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0022, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0033, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0044, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("post_rst_count", count_a, 1);
    check("post_rst_lane", lane_a, 0);
    check("ft_head_rdata", rdata_b, 64'h0044_0033_0022_0011);
    check("ft_head_rlanes", rlanes_b, 4'hF);
    check("std_no_ren_rdata", rdata_a, 0);
    drive(1'b0, 16'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("post_rst_rdata", rdata_a, 64'h0044_0033_0022_0011);
    check("post_rst_rlanes", rlanes_a, 4'hF);
    check("post_rst_empty", empty_a, 1);
    check("post_rst_ft_count", count_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
